// File: rtl/dac_sample_feeder.sv
// Sample FIFO feeding dac_control: releases one code per programmable period,
// holds the last code and flags a sticky underflow when a tick finds it empty.
module dac_sample_feeder #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int DIV_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   enable,
  input  logic [DIV_WIDTH-1:0]   rate_div,
  input  logic                   underflow_clr,
  output logic [WIDTH-1:0]       binary,
  output logic                   sample_strobe,
  output logic                   underflow,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     binary_q, binary_d;
  logic                 strobe_q, strobe_d;
  logic                 underflow_q, underflow_d;
  logic                 push, pop, tick;
  logic                 empty, full;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign push  = in_valid & ~full;
  // >= so that lowering rate_div below the count ticks right away
  assign tick  = enable & (cnt_q >= rate_div);
  // pop sees registered occupancy: a word pushed this cycle is not bypassed
  assign pop   = tick & ~empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    cnt_d       = '0;
    binary_d    = binary_q;
    strobe_d    = pop;
    underflow_d = underflow_q;
    if (enable && !tick) cnt_d = cnt_q + 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      binary_d = mem_q[rd_ptr_q];
    end
    unique case (1'b1)
      push && !pop: count_d = count_q + 1'b1;
      pop && !push: count_d = count_q - 1'b1;
      default:      count_d = count_q;
    endcase
    if (tick && empty)      underflow_d = 1'b1;
    else if (underflow_clr) underflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cnt_q       <= '0;
      binary_q    <= '0;
      strobe_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cnt_q       <= cnt_d;
      binary_q    <= binary_d;
      strobe_q    <= strobe_d;
      underflow_q <= underflow_d;
    end
  end

  assign in_ready      = ~full;
  assign binary        = binary_q;
  assign sample_strobe = strobe_q;
  assign underflow     = underflow_q;
  assign level         = count_q;

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Bench for dac_sample_feeder: directed pushes feed an expected-code queue,
// a negedge monitor pops it on every sample_strobe.
`timescale 1ns/1ps
module tb_dac_sample_feeder;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic          enable;
  logic [DW-1:0] rate_div;
  logic          underflow_clr;
  logic [W-1:0]  binary;
  logic          sample_strobe;
  logic          underflow;
  logic [4:0]    level;

  int vectors = 0;
  int errs    = 0;
  int cyc     = 0;
  logic [W-1:0] exp_q[$];
  int           strobe_cyc[$];
  logic [W-1:0] mon_e;

  dac_sample_feeder #(.WIDTH(W), .DEPTH(D), .DIV_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .enable(enable), .rate_div(rate_div),
    .underflow_clr(underflow_clr),
    .binary(binary), .sample_strobe(sample_strobe),
    .underflow(underflow), .level(level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // monitor: every strobe must carry the next expected code
  always @(negedge clk) begin
    if (rst === 1'b1 && sample_strobe === 1'b1) begin
      strobe_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        vectors++;
        errs++;
        $display("FAIL unexpected_strobe: got %0h want none", binary);
      end else begin
        mon_e = exp_q.pop_front();
        chk("binary", {24'd0, binary}, {24'd0, mon_e});
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(logic [W-1:0] d, bit expect_out);
    in_data  = d;
    in_valid = 1'b1;
    if (expect_out) exp_q.push_back(d);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(string nm);
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) step();
    vectors++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL %s: got %0d codes left want 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst = 1'b0; in_data = '0; in_valid = 1'b0; enable = 1'b0;
    rate_div = '0; underflow_clr = 1'b0;
    #1;
    chk("rst_binary", {24'd0, binary}, 32'h0);
    chk("rst_level", {27'd0, level}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_strobe", {31'd0, sample_strobe}, 32'd0);
    chk("rst_underflow", {31'd0, underflow}, 32'd0);
    #2 rst = 1'b1;
    step();

    // sweep at one code per cycle
    rate_div = 16'd0;
    enable   = 1'b1;
    for (int i = 0; i < 256; i++) push_word(W'(i), 1'b1);
    wait_drain("sweep_drain");
    chk("sweep_level", {27'd0, level}, 32'd0);
    chk("sweep_last", {24'd0, binary}, 32'hff);
    enable = 1'b0;
    underflow_clr = 1'b1;
    step();
    underflow_clr = 1'b0;
    chk("clr_underflow", {31'd0, underflow}, 32'd0);

    // period of four clocks
    rate_div = 16'd3;
    push_word(8'h10, 1'b1);
    push_word(8'h20, 1'b1);
    push_word(8'h30, 1'b1);
    push_word(8'h40, 1'b1);
    chk("rate_level", {27'd0, level}, 32'd4);
    strobe_cyc.delete();
    enable = 1'b1;
    wait_drain("rate_drain");
    step(8);
    chk("rate_hold", {24'd0, binary}, 32'h40);
    chk("rate_nstrobe", strobe_cyc.size(), 32'd4);
    for (int i = 1; i < strobe_cyc.size(); i++)
      chk("rate_gap", strobe_cyc[i] - strobe_cyc[i-1], 32'd4);
    enable = 1'b0;
    underflow_clr = 1'b1;
    step();
    underflow_clr = 1'b0;

    // fill to full; the 17th word must be refused
    for (int i = 0; i < 16; i++) push_word(8'hA0 + W'(i), 1'b1);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_level", {27'd0, level}, 32'd16);
    push_word(8'hB0, 1'b0);
    chk("full_level17", {27'd0, level}, 32'd16);
    rate_div = 16'd0;
    enable   = 1'b1;
    wait_drain("full_drain");
    enable = 1'b0;
    chk("full_empty", {27'd0, level}, 32'd0);
    chk("full_in_ready2", {31'd0, in_ready}, 32'd1);

    // underflow on an empty FIFO
    underflow_clr = 1'b1;
    step();
    underflow_clr = 1'b0;
    chk("uf_cleared", {31'd0, underflow}, 32'd0);
    rate_div = 16'd1;
    enable   = 1'b1;
    step();
    chk("uf_notick", {31'd0, underflow}, 32'd0);
    step();
    chk("uf_set", {31'd0, underflow}, 32'd1);
    chk("uf_hold", {24'd0, binary}, 32'haf);
    rate_div = 16'd0;
    underflow_clr = 1'b1;
    step();
    underflow_clr = 1'b0;
    chk("uf_set_wins", {31'd0, underflow}, 32'd1);
    enable = 1'b0;
    underflow_clr = 1'b1;
    step();
    underflow_clr = 1'b0;
    chk("uf_clr", {31'd0, underflow}, 32'd0);

    // push and tick together on empty: underflow, word stays queued
    enable   = 1'b1;
    in_data  = 8'h5A;
    in_valid = 1'b1;
    exp_q.push_back(8'h5A);
    step();
    in_valid = 1'b0;
    chk("nobypass_uf", {31'd0, underflow}, 32'd1);
    chk("nobypass_level", {27'd0, level}, 32'd1);
    wait_drain("nobypass_drain");
    enable = 1'b0;

    // asynchronous reset while running
    for (int i = 1; i <= 5; i++) push_word(W'(i), 1'b0);
    chk("mid_level", {27'd0, level}, 32'd5);
    rate_div = 16'd2;
    enable   = 1'b1;
    step();
    chk("mid_level_run", {27'd0, level}, 32'd5);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_level", {27'd0, level}, 32'd0);
    chk("mid_rst_binary", {24'd0, binary}, 32'h0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_uf", {31'd0, underflow}, 32'd0);
    enable = 1'b0;
    #2 rst = 1'b1;
    step();
    push_word(8'h77, 1'b1);
    push_word(8'h88, 1'b1);
    enable = 1'b1;
    wait_drain("mid_drain");
    chk("mid_last", {24'd0, binary}, 32'h88);
    enable = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
